// File: rtl/rank_change_logger.sv
// Captures each change of the tracked value with a cycle stamp into a FWFT FIFO; change visible one edge later.
// Head drains on out_valid && out_ready; a change arriving while full without a pop is dropped and counted.
module rank_change_logger #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int STAMP_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_value,
  output logic [STAMP_WIDTH-1:0]  out_stamp,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic [7:0]              drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]          PTR_ONE   = 1;
  localparam logic [STAMP_WIDTH-1:0] STAMP_ONE = 1;

  logic [DATA_WIDTH-1:0]  mem_value [DEPTH];
  logic [STAMP_WIDTH-1:0] mem_stamp [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [DATA_WIDTH-1:0]  prev;
  logic [STAMP_WIDTH-1:0] stamp;
  logic                   empty;
  logic                   full;
  logic                   change;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Pointers carry a wrap bit so full and empty are distinguishable at equal indices.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign change = (din != prev);
  assign pop    = !empty && out_ready;
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;

  assign out_valid  = !empty;
  assign fill_level = wr_ptr - rd_ptr;
  assign out_value  = empty ? '0 : mem_value[rd_ptr[AW-1:0]];
  assign out_stamp  = empty ? '0 : mem_stamp[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      prev       <= '0;
      stamp      <= '0;
      drop_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_value[i] <= '0;
        mem_stamp[i] <= '0;
      end
    end else begin
      prev  <= din;
      stamp <= stamp + STAMP_ONE;
      if (push) begin
        mem_value[wr_ptr[AW-1:0]] <= din;
        mem_stamp[wr_ptr[AW-1:0]] <= stamp;
        wr_ptr                    <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end
endmodule

// File: doc/rank_change_logger.md
# rank_change_logger

Downstream consumer of the running second-largest tracker. The tracker's output is sampled on every clock edge. Whenever the value changes, the block captures it together with a free-running cycle stamp in a small first-word-fall-through (FWFT) FIFO. Records drain over a valid/ready interface to the host/debug path, and records lost to a full FIFO are counted.

## Interface
- DATA_WIDTH, 32, width of the tracked value.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- STAMP_WIDTH, 16, width of the cycle stamp.
- clk  input  1  clock, all state on rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- din  input  DATA_WIDTH  tracker output, sampled every edge (no valid).
- out_valid  output  1  head record present.
- out_ready  input  1  consumer accepts head this edge.
- out_value  output  DATA_WIDTH  head record value; 0 when out_valid=0.
- out_stamp  output  STAMP_WIDTH  head record stamp; 0 when out_valid=0.
- fill_level  output  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- drop_count  output  8  saturating count of discarded change events.

## Operation
- Stamp counter: 0 in reset; +1 on every edge; wraps modulo 2^STAMP_WIDTH. The stamp attached to an event is the counter value *before* that edge's increment. The first edge after reset release therefore carries stamp 0.
- prev register: 0 in reset; loads din on every edge.
- Change event on an edge: din != prev. Because prev resets to 0, an initial din of 0 produces no event.
- Push on event if fill_level < DEPTH, or if a pop occurs on the same edge. Entry = {din, stamp}.
- Event with FIFO full and no pop: record discarded. drop_count +1, saturating at 255 (never wraps).
- Pop = out_valid && out_ready. Advances the read pointer.
- Push and pop on the same edge: fill_level unchanged, and both take effect. This also applies when full.
- Pointers: log2(DEPTH)+1 bits with wrap bit. Empty when pointers are equal; full when they differ only in the MSB.
- out_valid = (fill_level != 0). out_value/out_stamp are combinational from the head entry, forced to 0 when empty.
- out_ready while empty is ignored.
- Reset (any time, asynchronous) clears:
  - FIFO contents and pointers;
  - prev, stamp, drop_count;
  - all outputs.
  Reset values: out_valid=0, out_value=0, out_stamp=0, fill_level=0, drop_count=0. In-flight records are discarded with no drop count.

## Timing
- Event at edge N with the FIFO empty: out_valid=1 in the cycle after edge N, with out_stamp = N.
- Event-to-visible latency: 1 edge. There is no combinational path from din to any output.
- out_ready→pop: the same edge. The next head is visible after that edge.
- Back-to-back changes on consecutive edges are each captured, up to DEPTH without draining.
- The upstream tracker outputs 0 for its first two cycles after reset. The first logged record therefore appears no earlier than edge 2.
- fill_level and drop_count are registered and update on the edge of the push/pop/drop.

## Test plan
1. Single event:
   - Stimulus: after reset, din=0 for edges 0–2, din=7 from edge 3, out_ready=1.
   - Response: exactly one record {7,3}, out_valid high for one cycle, fill_level returns to 0, drop_count=0.
2. Overflow:
   - Stimulus: out_ready=0; din=1,2,3,4,5,6 on edges 0–5.
   - Response: FIFO holds (1,0)(2,1)(3,2)(4,3); fill_level=4; drop_count=2. Draining with out_ready=1 yields those four records in order.
3. Full with simultaneous pop:
   - Stimulus: fill to 4; at the next edge, din changes to 9 with out_ready=1.
   - Response: head popped and {9,stamp} pushed; fill_level stays 4; drop_count unchanged.
4. Drop saturation:
   - Stimulus: out_ready=0; din alternates 1/2 for 300 edges.
   - Response: 4 records stored, drop_count=255 and holding (296 drops).
5. Stamp wrap:
   - Stimulus: STAMP_WIDTH=4; din=0 until edge 17, then din=5.
   - Response: record {5,1}.
6. Reset mid-operation:
   - Stimulus: 3 entries held and drop_count=1; resetn driven low between edges.
   - Response: out_valid, fill_level and drop_count drop to 0 immediately, without a clock edge. After release, a change at the first edge carries stamp 0.
